booth_arbiter: RTL and testbench

BOOTH_ARBITER -- requirements
Module: booth_arbiter

---
 rtl/booth_arbiter_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 27 ++
 rtl/booth_arbiter.sv | 146 ++++++++++++++
 tb/tb_booth_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_arbiter_pkg.sv
// Shared definitions for the Booth job arbiter and the multiplier it drives:
// operand/product widths and the arbiter FSM encoding.
package booth_arbiter_pkg;

  localparam int OP_W   = 5;
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD_A,
    LOAD_B,
    WAIT,
    CAP_HI,
    CAP_LO,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The requester that was not served last wins a tie.
// last_served comes out of reset as 1, so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic served_id,
  output logic grant_valid,
  output logic grant_id
);

  logic last_served;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_served <= 1'b1;
    end else if (update) begin
      last_served <= served_id;
    end
  end

  assign grant_valid = req0 | req1;
  assign grant_id    = (req0 & req1) ? ~last_served : req1;

endmodule

// File: rtl/booth_arbiter.sv
// Serves two requesters on one shared Booth multiplier: arbitrates, streams the
// operands, waits (with timeout) for the product and returns it with an ack pulse.
//
// state  | meaning
// IDLE   | no job; arbitrate and latch winner id and operands
// START  | mul_start pulse to the multiplier
// LOAD_A | present latched a on mul_data_in
// LOAD_B | present latched b on mul_data_in
// WAIT   | wait for mul_done, abort with err after TIMEOUT cycles
// CAP_HI | high product half latched on entry
// CAP_LO | low product half latched on entry
// RESP   | ack/result/err valid for one cycle, last_served updated
module booth_arbiter
  import booth_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [OP_W-1:0]   a0,
  input  logic [OP_W-1:0]   b0,
  input  logic [OP_W-1:0]   a1,
  input  logic [OP_W-1:0]   b1,
  output logic              ack0,
  output logic              ack1,
  output logic [PROD_W-1:0] result,
  output logic              err,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_data_in,
  input  logic              mul_done,
  input  logic [OP_W-1:0]   mul_data_out,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             id_q;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic [OP_W-1:0]  hi_q;
  logic [OP_W-1:0]  lo_q;
  logic [CNT_W-1:0] cnt;
  logic             grant_valid;
  logic             grant_id;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .update      (state == RESP),
    .served_id   (id_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Outputs are registered: each transition sets what the next state presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt         <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      mul_start   <= 1'b0;
      mul_data_in <= '0;
      busy        <= 1'b0;
    end else begin
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      mul_start   <= 1'b0;
      mul_data_in <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state     <= START;
            id_q      <= grant_id;
            a_q       <= grant_id ? a1 : a0;
            b_q       <= grant_id ? b1 : b0;
            mul_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        START: begin
          state       <= LOAD_A;
          mul_data_in <= a_q;
        end
        LOAD_A: begin
          state       <= LOAD_B;
          mul_data_in <= b_q;
        end
        LOAD_B: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          // A done arriving on the last allowed cycle still wins over the abort.
          if (mul_done) begin
            state <= CAP_HI;
            hi_q  <= mul_data_out;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= RESP;
            ack0  <= ~id_q;
            ack1  <= id_q;
            err   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAP_HI: begin
          state <= CAP_LO;
          lo_q  <= mul_data_out;
        end
        CAP_LO: begin
          state  <= RESP;
          ack0   <= ~id_q;
          ack1   <= id_q;
          result <= {hi_q, lo_q};
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_arbiter.sv
// Bench for booth_arbiter: a behavioural multiplier answers each job, expected
// jobs are queued in predicted arbitration order and checked against each ack.
module tb_booth_arbiter;
  import booth_arbiter_pkg::*;

  localparam int TO = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1;
  logic [OP_W-1:0]   a0, b0, a1, b1;
  logic              ack0, ack1;
  logic [PROD_W-1:0] result;
  logic              err;
  logic              mul_start;
  logic [OP_W-1:0]   mul_data_in;
  logic              mul_done;
  logic [OP_W-1:0]   mul_data_out;
  logic              busy;

  booth_arbiter #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .a0           (a0),
    .b0           (b0),
    .a1           (a1),
    .b1           (b1),
    .ack0         (ack0),
    .ack1         (ack1),
    .result       (result),
    .err          (err),
    .mul_start    (mul_start),
    .mul_data_in  (mul_data_in),
    .mul_done     (mul_done),
    .mul_data_out (mul_data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int a;
    int b;
    int res;
    int err;
    int lat;
  } job_t;

  job_t sb[$];
  int   bench_last = 1;

  int   m_phase = 0;
  int   m_wait = 0;
  int   m_delay = 1;
  int   m_start_cyc = 0;
  bit   m_hang = 1'b0;
  bit   m_spur = 1'b0;
  logic [OP_W-1:0] m_a, m_b;
  logic signed [PROD_W-1:0] m_prod;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_prod(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    int ai, bi;
    ai = $signed(a);
    bi = $signed(b);
    return (ai * bi) & 32'h3FF;
  endfunction

  task automatic push_job(input int id);
    job_t j;
    j.id  = id;
    j.a   = id ? int'(a1) : int'(a0);
    j.b   = id ? int'(b1) : int'(b0);
    j.res = m_hang ? 0 : exp_prod(id ? a1 : a0, id ? b1 : b0);
    j.err = m_hang ? 1 : 0;
    j.lat = m_hang ? 3 + TO : 5 + m_delay;
    sb.push_back(j);
  endtask

  // Multiplier model: takes a then b after mul_start, answers after m_delay
  // WAIT cycles with the high half on the done cycle and the low half next.
  always @(negedge clk) begin
    mul_done     = 1'b0;
    mul_data_out = '0;
    if (rst) begin
      m_phase = 0;
    end else if ((m_phase == 0 || m_phase == 3) && mul_start) begin
      chk("start_data_zero", int'(mul_data_in), 0);
      m_start_cyc = cyc;
      m_phase = 1;
    end else begin
      case (m_phase)
        1: begin
          chk("start_pulse", int'(mul_start), 0);
          m_a = mul_data_in;
          if (sb.size() > 0) chk("data_a", int'(mul_data_in), sb[0].a);
          m_phase = 2;
        end
        2: begin
          m_b = mul_data_in;
          if (sb.size() > 0) chk("data_b", int'(mul_data_in), sb[0].b);
          m_prod = $signed(m_a) * $signed(m_b);
          m_wait = 0;
          if (m_spur) begin
            mul_done     = 1'b1;
            mul_data_out = 5'h1f;
          end
          m_phase = 3;
        end
        3: begin
          m_wait++;
          if (!m_hang && m_wait == m_delay) begin
            mul_done     = 1'b1;
            mul_data_out = m_prod[9:5];
            m_phase = 4;
          end
        end
        4: begin
          mul_data_out = m_prod[4:0];
          m_phase = 0;
        end
        default: ;
      endcase
    end
  end

  task automatic run_jobs(input bit r0, input bit r1, input int delay, input bit hang,
                          input bit spur, input bit drop0_early);
    job_t e;
    int   budget;
    int   first;
    m_delay = delay;
    m_hang  = hang;
    m_spur  = spur;
    if (r0 && r1) begin
      first = (bench_last == 1) ? 0 : 1;
      push_job(first);
      push_job(1 - first);
    end else if (r0) begin
      push_job(0);
    end else begin
      push_job(1);
    end
    req0 = r0;
    req1 = r1;
    budget = 0;
    while (sb.size() > 0 && budget < 400) begin
      @(negedge clk);
      budget++;
      if (mul_start) begin
        chk("busy_in_job", int'(busy), 1);
        if (drop0_early) begin
          req0 = 1'b0;
          a0   = ~a0;
        end
      end
      if (ack0 || ack1) begin
        e = sb.pop_front();
        chk("ack_both", int'(ack0 & ack1), 0);
        chk("ack_id", int'(ack1), e.id);
        chk("result", int'(result), e.res);
        chk("err", int'(err), e.err);
        chk("latency", cyc - m_start_cyc, e.lat);
        bench_last = e.id;
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
      end
    end
    if (sb.size() > 0) begin
      chk("job_timeout", sb.size(), 0);
      sb.delete();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ack0"}, int'(ack0), 0);
    chk({tag, "_ack1"}, int'(ack1), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_mul_start"}, int'(mul_start), 0);
    chk({tag, "_mul_data_in"}, int'(mul_data_in), 0);
  endtask

  initial begin
    int acks;
    int wait_cnt;
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    #2 rst = 1'b0;
    @(negedge clk);

    // first tie after reset goes to 0, then 1; second tie goes to 0 again
    a0 = 5'b00011; b0 = 5'b11110; a1 = 5'd7; b1 = 5'd5;
    run_jobs(1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    a0 = 5'b10000; b0 = 5'b10000; a1 = 5'b11111; b1 = 5'b01111;
    run_jobs(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);

    // done on the last allowed WAIT cycle, with a stray done before WAIT
    a1 = 5'b10000; b1 = 5'b01111;
    run_jobs(1'b0, 1'b1, TO, 1'b0, 1'b1, 1'b0);

    // timeout, then a normal job
    a0 = 5'd9; b0 = 5'd9;
    run_jobs(1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    a0 = 5'b00011; b0 = 5'b11110;
    run_jobs(1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0);

    // requester drops req and changes operands mid-job
    a0 = 5'd9; b0 = 5'b11001;
    run_jobs(1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1);

    // reset during WAIT abandons the job
    a0 = 5'd3; b0 = 5'd7;
    m_delay = 30; m_hang = 1'b0; m_spur = 1'b0;
    push_job(0);
    req0 = 1'b1;
    wait_cnt = 0;
    while (!mul_start && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("rst_test_start_seen", int'(mul_start), 1);
    repeat (5) @(negedge clk);
    chk("rst_test_busy_before", int'(busy), 1);
    #2 rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midjob_rst");
    sb.delete();
    bench_last = 1;
    #2 rst = 1'b0;
    acks = 0;
    repeat (40) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    chk("no_ack_after_rst", acks, 0);
    a1 = 5'b01111; b1 = 5'b01111;
    run_jobs(1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      bit r0, r1;
      r0 = bit'($urandom_range(0, 1));
      r1 = bit'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      a0 = 5'($urandom); b0 = 5'($urandom);
      a1 = 5'($urandom); b1 = 5'($urandom);
      run_jobs(r0, r1, int'($urandom_range(1, 10)), 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
